// File: rtl/layer5_result_mem_ctrl_pkg.sv
// Shared state type and sizing for the layer-5 result buffer sequencer.
package layer5_ctrl_pkg;

    localparam int unsigned MAP_DIM = 5;

    // Counter width needed to index 0..dim-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(MAP_DIM);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FULL  = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/layer5_result_mem_ctrl_if.sv
// Write-side and read-side signals between layer 5, the result buffer and layer 6.
interface layer5_result_mem_ctrl_if #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned FRAME_CNT_W = 8
);
    logic                   layer5_valid;
    logic                   layer5_ready;
    logic                   save_enable;
    logic [ADDR_W-1:0]      save_row_addr;
    logic [ADDR_W-1:0]      save_col_addr;
    logic                   layer6_start;
    logic                   layer6_stall;
    logic                   layer5_result_read_signal;
    logic [ADDR_W-1:0]      read_row_addr;
    logic [ADDR_W-1:0]      read_col_addr;
    logic                   read_last;
    logic                   map_full;
    logic [FRAME_CNT_W-1:0] frame_count;

    // Controller side.
    modport slave (
        input  layer5_valid, layer6_start, layer6_stall,
        output layer5_ready, save_enable, save_row_addr, save_col_addr,
               layer5_result_read_signal, read_row_addr, read_col_addr,
               read_last, map_full, frame_count
    );

    // Producer / consumer side.
    modport master (
        output layer5_valid, layer6_start, layer6_stall,
        input  layer5_ready, save_enable, save_row_addr, save_col_addr,
               layer5_result_read_signal, read_row_addr, read_col_addr,
               read_last, map_full, frame_count
    );
endinterface

// File: rtl/layer5_result_mem_ctrl_map_raster_counter.sv
// Raster-order row/col counter over a MAP_DIM x MAP_DIM map; wraps to (0,0) after the last entry.
module map_raster_counter #(
    parameter  int unsigned MAP_DIM = layer5_ctrl_pkg::MAP_DIM,
    localparam int unsigned CW      = layer5_ctrl_pkg::cnt_width(MAP_DIM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [CW-1:0] row_o,
    output logic [CW-1:0] col_o,
    output logic          last_o
);
    localparam logic [CW-1:0] LAST_IDX = CW'(MAP_DIM - 1);

    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    // Clear wins over increment; column wraps carry into the row.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (inc_i) begin
            if (col_q == LAST_IDX) begin
                col_d = '0;
                row_d = (row_q == LAST_IDX) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == LAST_IDX) && (col_q == LAST_IDX);

endmodule

// File: rtl/layer5_result_mem_ctrl.sv
// Fills the layer-5 result map in raster order, then drains it to layer 6 on request.
module layer5_result_mem_ctrl #(
    parameter int unsigned MAP_DIM     = layer5_ctrl_pkg::MAP_DIM,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned FRAME_CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    layer5_result_mem_ctrl_if.slave  bus
);
    import layer5_ctrl_pkg::*;

    localparam int unsigned CW = cnt_width(MAP_DIM);

    ctrl_state_t state_q, state_d;

    logic                   wr_inc, wr_clr, rd_inc, rd_clr;
    logic                   ready, full, rd_en, save_en, drain_done;
    logic [CW-1:0]          wr_row, wr_col, rd_row, rd_col;
    logic                   wr_last, rd_last;
    logic [FRAME_CNT_W-1:0] frame_q, frame_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FILL;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
        end
    end

    // Next-state: a stalled last read keeps the drain going.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (bus.layer5_valid && wr_last) state_d = FULL;
            FULL:    if (bus.layer6_start)            state_d = DRAIN;
            DRAIN:   if (!bus.layer6_stall && rd_last) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Outputs and counter controls decoded from the current state.
    always_comb begin
        ready      = 1'b0;
        full       = 1'b0;
        rd_en      = 1'b0;
        save_en    = 1'b0;
        wr_inc     = 1'b0;
        wr_clr     = 1'b0;
        rd_inc     = 1'b0;
        rd_clr     = 1'b0;
        drain_done = 1'b0;
        case (state_q)
            FILL: begin
                ready   = 1'b1;
                save_en = bus.layer5_valid;
                wr_inc  = bus.layer5_valid;
                rd_clr  = 1'b1;
            end
            FULL: begin
                full   = 1'b1;
                wr_clr = 1'b1;
                rd_clr = 1'b1;
            end
            DRAIN: begin
                rd_en      = 1'b1;
                rd_inc     = !bus.layer6_stall;
                drain_done = !bus.layer6_stall && rd_last;
                wr_clr     = 1'b1;
            end
            default: begin
                wr_clr = 1'b1;
                rd_clr = 1'b1;
            end
        endcase
    end

    assign frame_d = drain_done ? frame_q + FRAME_CNT_W'(1) : frame_q;

    map_raster_counter #(.MAP_DIM(MAP_DIM)) u_wr_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (wr_inc),
        .clr_i  (wr_clr),
        .row_o  (wr_row),
        .col_o  (wr_col),
        .last_o (wr_last)
    );

    map_raster_counter #(.MAP_DIM(MAP_DIM)) u_rd_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (rd_inc),
        .clr_i  (rd_clr),
        .row_o  (rd_row),
        .col_o  (rd_col),
        .last_o (rd_last)
    );

    assign bus.layer5_ready              = ready;
    assign bus.save_enable               = save_en;
    assign bus.save_row_addr             = ADDR_W'(wr_row);
    assign bus.save_col_addr             = ADDR_W'(wr_col);
    assign bus.layer5_result_read_signal = rd_en;
    assign bus.read_row_addr             = ADDR_W'(rd_row);
    assign bus.read_col_addr             = ADDR_W'(rd_col);
    assign bus.read_last                 = rd_en && rd_last;
    assign bus.map_full                  = full;
    assign bus.frame_count               = frame_q;

endmodule

// File: doc/layer5_result_mem_ctrl.md
Name: layer5_result_mem_ctrl

Overview:
Sequencer for the 5x5 layer-5 result buffer sitting between the layer-5 output stage and the layer-6 input stage. It accepts layer-5 results in raster order and generates save_enable and save row/col addresses. Once the map is full, it drains the buffer to layer 6 in raster order on request. Writes are back-pressured while the buffer drains, so one frame is buffered at a time.

Parameters:
MAP_DIM, 5, rows and columns of the result map (entries = MAP_DIM*MAP_DIM)
ADDR_W, 16, width of the row/col address outputs
FRAME_CNT_W, 8, width of the completed-frame counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
layer5_valid  in  1  layer-5 result available this cycle
layer5_ready  out  1  controller can accept a write (state FILL)
save_enable  out  1  buffer write strobe
save_row_addr  out  ADDR_W  write row
save_col_addr  out  ADDR_W  write column
layer6_start  in  1  layer 6 requests a drain of the full map
layer6_stall  in  1  hold the current read address
layer5_result_read_signal  out  1  buffer read enable
read_row_addr  out  ADDR_W  read row
read_col_addr  out  ADDR_W  read column
read_last  out  1  current read is entry (MAP_DIM-1, MAP_DIM-1)
map_full  out  1  map complete, awaiting layer6_start
frame_count  out  FRAME_CNT_W  number of completed drains, wraps

Behaviour:
- Reset (rst==0 at a rising edge): state=FILL; write and read counters=0; frame_count=0. Resulting outputs: save_row/col=0, read_row/col=0, layer5_result_read_signal=0, read_last=0, map_full=0. layer5_ready=1 (combinational from state FILL).
- Reset mid-operation discards the partial fill or drain. The controller does not clear buffer contents.
- States: FILL, FULL, DRAIN.
- save_enable = layer5_valid & (state==FILL). This is combinational and asserted in the same cycle as the address, because the buffer writes at the next edge.
- save_row/col_addr are registered write counters, zero-extended to ADDR_W, always driven.
- FILL, per accepted write:
  - col++.
  - When col==MAP_DIM-1: col wraps to 0 and row++.
  - Write to (MAP_DIM-1, MAP_DIM-1): counters clear to 0 and next state is FULL.
  - layer5_valid low: counters hold.
- FULL:
  - map_full=1, layer5_ready=0, save_enable=0.
  - layer6_start=1 -> next state DRAIN with read counters at (0,0).
  - layer6_start is sampled only in FULL. In FILL or DRAIN it is ignored and not latched.
- DRAIN:
  - layer5_result_read_signal=1 for every cycle in DRAIN. Read data is valid in the same cycle (combinational buffer read); layer 6 samples it at the following edge.
  - layer6_stall=1: read counters hold.
  - Otherwise the counters advance in raster order, same wrap rule as the write counters.
  - read_last = read_signal & (row==MAP_DIM-1) & (col==MAP_DIM-1).
  - Unstalled cycle with read_last=1: next state FILL, read counters clear, frame_count++ (wraps 2^FRAME_CNT_W-1 -> 0).
  - A stalled last read stays in DRAIN.
- read_row/col_addr are 0 and read_signal is 0 outside DRAIN.
- Drain latency: 1 cycle from layer6_start to the first read. Minimum drain length is MAP_DIM*MAP_DIM cycles plus stall cycles.
- Minimum frame period is 25 + 1 + 25 cycles.
- Addresses never exceed MAP_DIM-1. Only the low bits are nonzero.

Decomposition:
- Package layer5_ctrl_pkg:
  - state enum typedef ctrl_state_t {FILL, FULL, DRAIN}
  - localparam MAP_DIM default
  - localparam CNT_W = $clog2(MAP_DIM)
- Sub-module map_raster_counter: row/col counter with inc, clr and a last flag, wrap at MAP_DIM. Instantiated twice, once for write and once for read.

Test Plan:
- Back-to-back fill: layer5_valid=1 for 25 cycles -> save addrs (0,0),(0,1)..(0,4),(1,0)..(4,4), save_enable for 25 cycles. map_full=1 on cycle 26 and layer5_ready=0.
- Gapped fill: valid toggles 1/0 -> addresses advance only on valid cycles. 50 cycles to FULL, no skipped or duplicated address.
- Drain with stalls: layer6_start in FULL, stall high on reads 3 and 17 -> read addr (0,2) held 2 cycles, (3,1) held 2 cycles. read_last at (4,4). FILL next, frame_count=1.
- Ignored start and backpressure: layer6_start pulsed in FILL -> no drain. layer5_valid=1 during FULL/DRAIN -> save_enable=0 and write counters stay 0.
- Reset mid-drain: rst=0 at read (2,3) -> next cycle state FILL, read_signal=0, all addrs 0, frame_count=0.
- Counter wrap: 256 complete frames -> frame_count returns to 0.
